// File: rtl/status_text_scroller.sv
// status_text_scroller
// Turns the recorder operating mode into four letter codes for the
// seven-segment letter decoders: PLAY, STOP, DEL, a scrolling RECORD,
// or blank. An internal tick divider paces the REC scroll and the
// alert blink. The letter outputs decode registered state only.
module status_text_scroller #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic       alert,
    output logic [3:0] letter3,
    output logic [3:0] letter2,
    output logic [3:0] letter1,
    output logic [3:0] letter0,
    output logic       tick
);

    localparam int              DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(TICK_DIV - 1);

    localparam logic [2:0] MODE_PLAY = 3'd1;
    localparam logic [2:0] MODE_REC  = 3'd2;
    localparam logic [2:0] MODE_STOP = 3'd3;
    localparam logic [2:0] MODE_DEL  = 3'd4;

    localparam logic [3:0] L_A     = 4'd0;
    localparam logic [3:0] L_C     = 4'd1;
    localparam logic [3:0] L_D     = 4'd2;
    localparam logic [3:0] L_E     = 4'd3;
    localparam logic [3:0] L_L     = 4'd4;
    localparam logic [3:0] L_O     = 4'd5;
    localparam logic [3:0] L_P     = 4'd6;
    localparam logic [3:0] L_R     = 4'd7;
    localparam logic [3:0] L_S     = 4'd8;
    localparam logic [3:0] L_T     = 4'd9;
    localparam logic [3:0] L_Y     = 4'd10;
    localparam logic [3:0] L_BLANK = 4'd15;

    logic [2:0]    r_mode;
    logic [2:0]    r_ofs;
    logic [DW-1:0] r_div;
    logic          r_phase;

    logic          w_mode_chg;
    logic          w_div_last;
    logic          w_tick;
    logic [3:0]    w_rec_sym [4];
    logic [3:0]    w_text    [4];
    logic [3:0]    w_letter  [4];

    // Circular REC message R,E,C,O,R,D,blank; index is ofs+0..ofs+3 (0..9).
    function automatic logic [3:0] msg_sym(input logic [3:0] idx);
        logic [3:0] sym;
        case (idx)
            4'd0, 4'd7: sym = L_R;
            4'd1, 4'd8: sym = L_E;
            4'd2, 4'd9: sym = L_C;
            4'd3:       sym = L_O;
            4'd4:       sym = L_R;
            4'd5:       sym = L_D;
            default:    sym = L_BLANK;
        endcase
        return sym;
    endfunction

    // A mode change restarts the divider, so a tick on that same edge is
    // suppressed and the pulse is withheld to match.
    assign w_mode_chg = (mode != r_mode);
    assign w_div_last = (r_div == DIV_LAST);
    assign w_tick     = w_div_last & ~w_mode_chg;
    assign tick       = w_tick;

    // Mode capture, tick divider, REC scroll offset and blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= 3'd0;
            r_ofs   <= 3'd0;
            r_div   <= '0;
            r_phase <= 1'b1;
        end else if (w_mode_chg) begin
            r_mode  <= mode;
            r_ofs   <= 3'd0;
            r_div   <= '0;
            r_phase <= 1'b1;
        end else begin
            r_div <= w_div_last ? '0 : r_div + DW'(1);
            if (w_tick && (r_mode == MODE_REC)) begin
                r_ofs <= (r_ofs == 3'd6) ? 3'd0 : r_ofs + 3'd1;
            end
            if (!alert) begin
                r_phase <= 1'b1;
            end else if (w_tick) begin
                r_phase <= ~r_phase;
            end
        end
    end

    // Scroll window: digit gi shows M[ofs + 3 - gi], so letter3 leads.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rec
            assign w_rec_sym[gi] = msg_sym({1'b0, r_ofs} + 4'(3 - gi));
        end
    endgenerate

    // Word selection from the registered mode; 0 and 5..7 are blank.
    always_comb begin
        w_text[3] = L_BLANK;
        w_text[2] = L_BLANK;
        w_text[1] = L_BLANK;
        w_text[0] = L_BLANK;
        case (r_mode)
            MODE_PLAY: begin
                w_text[3] = L_P;
                w_text[2] = L_L;
                w_text[1] = L_A;
                w_text[0] = L_Y;
            end
            MODE_STOP: begin
                w_text[3] = L_S;
                w_text[2] = L_T;
                w_text[1] = L_O;
                w_text[0] = L_P;
            end
            MODE_DEL: begin
                w_text[3] = L_D;
                w_text[2] = L_E;
                w_text[1] = L_L;
                w_text[0] = L_BLANK;
            end
            MODE_REC: begin
                w_text[3] = w_rec_sym[3];
                w_text[2] = w_rec_sym[2];
                w_text[1] = w_rec_sym[1];
                w_text[0] = w_rec_sym[0];
            end
            default: ;
        endcase
    end

    // Blink-off phase blanks every digit regardless of mode.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blank
            assign w_letter[gi] = r_phase ? w_text[gi] : L_BLANK;
        end
    endgenerate

    assign letter3 = w_letter[3];
    assign letter2 = w_letter[2];
    assign letter1 = w_letter[1];
    assign letter0 = w_letter[0];

endmodule

// File: tb/tb_status_text_scroller.sv
// Scoreboard bench for status_text_scroller with TICK_DIV=4: expected
// letter words are queued as each cycle is driven and compared after it.
module tb_status_text_scroller;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] mode = 3'd1;
    logic       alert = 1'b0;
    logic [3:0] letter3, letter2, letter1, letter0;
    logic       tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];
    logic [3:0]  msg [7] = '{4'd7, 4'd3, 4'd1, 4'd5, 4'd7, 4'd2, 4'd15};

    localparam logic [15:0] W_PLAY  = 16'h640A;
    localparam logic [15:0] W_STOP  = 16'h8956;
    localparam logic [15:0] W_DEL   = 16'h234F;
    localparam logic [15:0] W_BLANK = 16'hFFFF;

    status_text_scroller #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .alert   (alert),
        .letter3 (letter3),
        .letter2 (letter2),
        .letter1 (letter1),
        .letter0 (letter0),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rec_word(input int ofs);
        return {msg[ofs % 7], msg[(ofs + 1) % 7], msg[(ofs + 2) % 7], msg[(ofs + 3) % 7]};
    endfunction

    task automatic compare_pop(input string tag);
        logic [15:0] e;
        logic [15:0] obs;
        obs = {letter3, letter2, letter1, letter0};
        if (exp_q.size() == 0) begin
            check_value({tag, "_empty_queue"}, 16'h0000, 16'hFFFF);
        end else begin
            e = exp_q.pop_front();
            $display("[TB] %s letters=%h expected=%h tick=%0b", tag, obs, e, tick);
            check_value(tag, obs, e);
        end
    endtask

    // One clock cycle: queue the expected word, clock, compare.
    task automatic step(input string tag, input logic [15:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_pop(tag);
    endtask

    task automatic check_tick(input string tag, input logic e);
        check_value(tag, {15'd0, tick}, {15'd0, e});
    endtask

    // Change to a fixed word and hold it for 10 cycles; two ticks expected.
    task automatic run_word(input string tag, input logic [2:0] m, input logic [15:0] w);
        int ticks;
        mode = m;
        step({tag, "_chg"}, w);
        ticks = 0;
        for (int k = 1; k <= 10; k++) begin
            step(tag, w);
            if (tick) ticks++;
        end
        check_value({tag, "_ticks"}, 16'(ticks), 16'd2);
    endtask

    initial begin
        // Reset held with mode=PLAY
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(W_BLANK);
        compare_pop("reset_letters");
        check_tick("reset_tick", 1'b0);
        rst_n = 1'b1;
        step("reset_release", W_PLAY);
        begin
            int ticks;
            ticks = 0;
            for (int k = 1; k <= 10; k++) begin
                step("play", W_PLAY);
                if (tick) ticks++;
            end
            check_value("play_ticks", 16'(ticks), 16'd2);
        end

        run_word("stop", 3'd3, W_STOP);
        run_word("del", 3'd4, W_DEL);
        run_word("idle6", 3'd6, W_BLANK);

        // REC scroll through a full wrap
        mode = 3'd2;
        for (int k = 0; k <= 31; k++) begin
            step("rec_scroll", rec_word(k / TD));
        end
        check_tick("pre_race_tick", 1'b1);

        // Mode change on the edge where div==TICK_DIV-1
        mode = 3'd3;
        #1;
        check_tick("race_tick", 1'b0);
        step("race_stop", W_STOP);
        for (int k = 1; k <= 3; k++) begin
            step("race_after", W_STOP);
            check_tick("race_next_tick", (k == 3));
        end

        // Blink on PLAY
        mode = 3'd1;
        step("blink_chg", W_PLAY);
        alert = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step("blink", (((k / TD) % 2) == 1) ? W_BLANK : W_PLAY);
        end
        alert = 1'b0;
        step("alert_off", W_PLAY);

        // Asynchronous reset mid-REC at ofs=3
        mode = 3'd2;
        for (int k = 0; k <= 13; k++) begin
            step("rec_pre_rst", rec_word(k / TD));
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(W_BLANK);
        compare_pop("async_reset");
        check_tick("async_reset_tick", 1'b0);
        #1;
        rst_n = 1'b1;
        step("rec_after_rst", rec_word(0));
        for (int k = 1; k <= 4; k++) begin
            step("rec_after_rst", rec_word(k / TD));
        end

        check_value("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
